// File: rtl/trap_redirect_if.sv
// Interface between the trap/return redirect controller and its neighbours.
// Carries the execute-stage instruction, the CSR unit's mtvec/mepc, the
// flush/busy pipeline controls, the fetch redirect handshake and the event
// counters.
//   master : pipeline side (drives execute instruction, CSR values, ready)
//   slave  : trap_redirect (drives flush, busy, redirect, counters)
interface trap_redirect_if #(
    parameter int CNT_W = 32
);
    logic              valid_i;
    logic [31:0]       pc;
    logic [31:0]       ir;
    logic [31:0]       mtvec;
    logic [31:0]       mepc;
    logic              flush;
    logic              busy;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              redirect_ready;
    logic [CNT_W-1:0]  trap_cnt;
    logic [CNT_W-1:0]  mret_cnt;

    modport master (
        output valid_i, pc, ir, mtvec, mepc, redirect_ready,
        input  flush, busy, redirect_valid, redirect_pc, trap_cnt, mret_cnt
    );

    modport slave (
        input  valid_i, pc, ir, mtvec, mepc, redirect_ready,
        output flush, busy, redirect_valid, redirect_pc, trap_cnt, mret_cnt
    );
endinterface

// File: rtl/trap_redirect.sv
// Next-PC redirect controller for ECALL/EBREAK (to mtvec) and MRET (to mepc),
// plus the boot redirect after reset.
// Ports:
//   clk    : system clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : trap_redirect_if.slave (execute instruction, CSR values,
//            flush/busy, redirect handshake, trap/mret counters)
//
// state      | meaning
// -----------+------------------------------------------------------------
// BOOT_REQ   | offering BOOT to fetch after reset, pipeline flushed
// IDLE       | watching execute for ECALL/EBREAK/MRET
// DRAIN      | flushing younger stages, counting down FLUSH_CYCLES
// REDIRECT   | offering the sampled target until fetch accepts it
module trap_redirect #(
    parameter logic [31:0] BOOT         = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    trap_redirect_if.slave  bus
);
    localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [31:0]   BOOT_PC    = BOOT & ~32'h3;

    typedef enum logic [1:0] {
        S_BOOT_REQ,
        S_IDLE,
        S_DRAIN,
        S_REDIRECT
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DW-1:0]     r_drain_cnt;
    logic [31:0]       r_target;
    logic              r_kind_ret;
    logic              r_out_en;
    logic [CNT_W-1:0]  r_trap_cnt;
    logic [CNT_W-1:0]  r_mret_cnt;

    logic              w_sys;
    logic              w_trap;
    logic              w_ret;
    logic              w_offer;
    logic              w_hs;

    // funct3==0 SYSTEM only; ir[21] separates MRET from ECALL/EBREAK
    assign w_sys  = bus.valid_i && (bus.ir[1:0] == 2'b11) && (bus.ir[6:2] == 5'b11100)
                    && (bus.ir[14:12] == 3'b000);
    assign w_trap = w_sys && !bus.ir[21];
    assign w_ret  = w_sys && bus.ir[21];

    // r_out_en keeps redirect_valid low while reset is asserted even though
    // the state register already sits in BOOT_REQ.
    assign w_offer = (r_state == S_BOOT_REQ) || (r_state == S_REDIRECT);
    assign w_hs    = bus.redirect_valid && bus.redirect_ready;

    assign bus.redirect_valid = r_out_en && w_offer;
    assign bus.redirect_pc    = r_target;
    assign bus.flush          = (r_state != S_IDLE);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.trap_cnt       = r_trap_cnt;
    assign bus.mret_cnt       = r_mret_cnt;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT_REQ: if (w_hs) w_next_state = S_IDLE;
            S_IDLE: begin
                if (w_trap || w_ret)
                    w_next_state = (FLUSH_CYCLES == 0) ? S_REDIRECT : S_DRAIN;
            end
            S_DRAIN:    if (r_drain_cnt == '0) w_next_state = S_REDIRECT;
            S_REDIRECT: if (w_hs) w_next_state = S_IDLE;
            default:    w_next_state = S_BOOT_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_BOOT_REQ;
            r_drain_cnt <= '0;
            r_target    <= BOOT_PC;
            r_kind_ret  <= 1'b0;
            r_out_en    <= 1'b0;
            r_trap_cnt  <= '0;
            r_mret_cnt  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_out_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    // CSR values are captured here; later changes cannot
                    // disturb the in-flight redirect.
                    if (w_trap || w_ret) begin
                        r_target    <= (w_trap ? bus.mtvec : bus.mepc) & ~32'h3;
                        r_kind_ret  <= w_ret;
                        r_drain_cnt <= DRAIN_INIT;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
                end
                S_REDIRECT: begin
                    if (w_hs) begin
                        if (r_kind_ret) r_mret_cnt <= r_mret_cnt + CNT_W'(1);
                        else            r_trap_cnt <= r_trap_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_redirect.sv
module tb_trap_redirect;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    trap_redirect_if #(.CNT_W(32)) bus_a ();
    trap_redirect_if #(.CNT_W(32)) bus_b ();

    trap_redirect #(.BOOT(32'h0000_0100), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    trap_redirect #(.BOOT(32'h0000_0000), .FLUSH_CYCLES(0), .CNT_W(32)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_a.valid_i = 0; bus_a.pc = 0; bus_a.ir = 0; bus_a.mtvec = 0; bus_a.mepc = 0;
        bus_a.redirect_ready = 1;
        bus_b.valid_i = 0; bus_b.pc = 0; bus_b.ir = 0; bus_b.mtvec = 0; bus_b.mepc = 0;
        bus_b.redirect_ready = 1;
        rst_n = 0;
        step(); step();

        // in reset
        chk("rst_flush", 32'(bus_a.flush), 1);
        chk("rst_busy", 32'(bus_a.busy), 1);
        chk("rst_valid", 32'(bus_a.redirect_valid), 0);
        chk("rst_pc", bus_a.redirect_pc, 32'h100);
        chk("rst_trap_cnt", bus_a.trap_cnt, 0);
        chk("rst_mret_cnt", bus_a.mret_cnt, 0);

        // boot redirect
        rst_n = 1;
        step();
        chk("boot_valid", 32'(bus_a.redirect_valid), 1);
        chk("boot_pc", bus_a.redirect_pc, 32'h100);
        chk("boot_flush", 32'(bus_a.flush), 1);
        chk("boot_b_pc", bus_b.redirect_pc, 32'h0);
        step();
        chk("boot_idle_valid", 32'(bus_a.redirect_valid), 0);
        chk("boot_idle_busy", 32'(bus_a.busy), 0);
        chk("boot_idle_flush", 32'(bus_a.flush), 0);
        chk("boot_trap_cnt", bus_a.trap_cnt, 0);
        chk("boot_mret_cnt", bus_a.mret_cnt, 0);
        chk("boot_b_busy", 32'(bus_b.busy), 0);

        // ECALL, 2 drain cycles + redirect cycle
        bus_a.valid_i = 1; bus_a.ir = 32'h0000_0073; bus_a.pc = 32'h40; bus_a.mtvec = 32'h203;
        step();
        bus_a.valid_i = 0;
        chk("ecall_flush1", 32'(bus_a.flush), 1);
        chk("ecall_valid1", 32'(bus_a.redirect_valid), 0);
        step();
        chk("ecall_flush2", 32'(bus_a.flush), 1);
        chk("ecall_valid2", 32'(bus_a.redirect_valid), 0);
        step();
        chk("ecall_flush3", 32'(bus_a.flush), 1);
        chk("ecall_valid3", 32'(bus_a.redirect_valid), 1);
        chk("ecall_pc", bus_a.redirect_pc, 32'h200);
        chk("ecall_cnt_pre", bus_a.trap_cnt, 0);
        step();
        chk("ecall_flush_end", 32'(bus_a.flush), 0);
        chk("ecall_valid_end", 32'(bus_a.redirect_valid), 0);
        chk("ecall_trap_cnt", bus_a.trap_cnt, 1);

        // MRET with fetch stalling
        bus_a.redirect_ready = 0;
        bus_a.valid_i = 1; bus_a.ir = 32'h3020_0073; bus_a.mepc = 32'h44;
        step();
        bus_a.valid_i = 0;
        step(); step();
        bus_a.mepc = 32'h88;
        for (int i = 0; i < 5; i++) begin
            chk("mret_hold_valid", 32'(bus_a.redirect_valid), 1);
            chk("mret_hold_pc", bus_a.redirect_pc, 32'h44);
            chk("mret_hold_cnt", bus_a.mret_cnt, 0);
            step();
        end
        chk("mret_last_valid", 32'(bus_a.redirect_valid), 1);
        bus_a.redirect_ready = 1;
        step();
        chk("mret_cnt", bus_a.mret_cnt, 1);
        chk("mret_trap_cnt", bus_a.trap_cnt, 1);
        chk("mret_end_valid", 32'(bus_a.redirect_valid), 0);
        chk("mret_end_busy", 32'(bus_a.busy), 0);

        // csrrw and invalid ECALL are ignored
        bus_a.valid_i = 1; bus_a.ir = 32'h3052_9073;
        step();
        chk("csrrw_busy", 32'(bus_a.busy), 0);
        chk("csrrw_flush", 32'(bus_a.flush), 0);
        bus_a.valid_i = 0; bus_a.ir = 32'h0000_0073;
        step();
        chk("novalid_busy", 32'(bus_a.busy), 0);
        chk("novalid_valid", 32'(bus_a.redirect_valid), 0);
        chk("ignored_trap_cnt", bus_a.trap_cnt, 1);
        chk("ignored_mret_cnt", bus_a.mret_cnt, 1);

        // EBREAK; mtvec changes and another ECALL arrives while busy
        bus_a.valid_i = 1; bus_a.ir = 32'h0010_0073; bus_a.mtvec = 32'h105;
        step();
        bus_a.mtvec = 32'h300; bus_a.ir = 32'h0000_0073;
        step(); step();
        chk("busy_ecall_valid", 32'(bus_a.redirect_valid), 1);
        chk("busy_ecall_pc", bus_a.redirect_pc, 32'h104);
        bus_a.valid_i = 0;
        step();
        chk("busy_ecall_cnt", bus_a.trap_cnt, 2);
        chk("busy_ecall_idle", 32'(bus_a.busy), 0);
        step();
        chk("busy_ecall_once", 32'(bus_a.busy), 0);
        chk("busy_ecall_cnt2", bus_a.trap_cnt, 2);

        // reset during REDIRECT
        bus_a.redirect_ready = 0;
        bus_a.valid_i = 1; bus_a.mtvec = 32'h400;
        step();
        bus_a.valid_i = 0;
        step(); step();
        chk("pre_rst_valid", 32'(bus_a.redirect_valid), 1);
        chk("pre_rst_pc", bus_a.redirect_pc, 32'h400);
        rst_n = 0;
        #1;
        chk("midrst_valid", 32'(bus_a.redirect_valid), 0);
        chk("midrst_busy", 32'(bus_a.busy), 1);
        chk("midrst_pc", bus_a.redirect_pc, 32'h100);
        chk("midrst_trap_cnt", bus_a.trap_cnt, 0);
        chk("midrst_mret_cnt", bus_a.mret_cnt, 0);
        step();
        rst_n = 1;
        bus_a.redirect_ready = 1;
        step(); step();
        chk("rerun_a_idle", 32'(bus_a.busy), 0);
        chk("rerun_b_idle", 32'(bus_b.busy), 0);

        // zero drain cycles: redirect offered the cycle after detection
        bus_b.valid_i = 1; bus_b.ir = 32'h0000_0073; bus_b.mtvec = 32'h55;
        step();
        bus_b.valid_i = 0;
        chk("fc0_valid", 32'(bus_b.redirect_valid), 1);
        chk("fc0_pc", bus_b.redirect_pc, 32'h54);
        chk("fc0_flush", 32'(bus_b.flush), 1);
        chk("fc0_cnt_pre", bus_b.trap_cnt, 0);
        step();
        chk("fc0_end_valid", 32'(bus_b.redirect_valid), 0);
        chk("fc0_end_flush", 32'(bus_b.flush), 0);
        chk("fc0_trap_cnt", bus_b.trap_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
